// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32IM pipeline defaults and the index/data types used
//               by the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_idx_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// ============================================================================
// Module      : regfile_sb_scoreboard
// Description : Per-register busy bits (set at issue, cleared at writeback,
//               dropped on flush), incremental busy counter and read-side busy
//               lookup. Macro REGFILE_DBG_EN exposes the raw busy vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb_scoreboard
    import rv_pkg::*;
#(
    parameter  int NREG   = NREG_DEFAULT,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_rd,
    input  logic          i_wb_valid,
    input  logic [AW-1:0] i_wb_rd,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy,
    output logic [AW:0]   o_busy_cnt
`ifdef REGFILE_DBG_EN
    ,
    output logic [NREG-1:0] o_busy_vec
`endif
);

    localparam logic [AW:0] C_CNT_ONE = (AW+1)'(1);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     r_busy_cnt;
    logic            w_inc;
    logic            w_dec;
    logic            w_same_rd;
    logic            w_wb_hit1;
    logic            w_wb_hit2;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < NREG; r++) begin
            if (i_flush)
                w_busy_nxt[r] = 1'b0;
            else if (i_issue_valid && (i_issue_rd == AW'(r)))
                w_busy_nxt[r] = 1'b1;
            else if (i_wb_valid && (i_wb_rd == AW'(r)))
                w_busy_nxt[r] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Counter tracks the popcount incrementally: one set and one clear per cycle at most.
    assign w_same_rd = i_issue_valid && (i_issue_rd == i_wb_rd);
    assign w_inc     = i_issue_valid && (i_issue_rd != '0) && !r_busy[i_issue_rd];
    assign w_dec     = i_wb_valid && (i_wb_rd != '0) && r_busy[i_wb_rd] && !w_same_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (i_flush)
                r_busy_cnt <= '0;
            else if (w_inc && !w_dec)
                r_busy_cnt <= r_busy_cnt + C_CNT_ONE;
            else if (w_dec && !w_inc)
                r_busy_cnt <= r_busy_cnt - C_CNT_ONE;
        end
    end

    // A forwarded writeback clears the read-side busy unless re-issued this cycle.
    assign w_wb_hit1 = (BYPASS != 0) && i_wb_valid && (i_wb_rd == i_rs1) && (i_rs1 != '0);
    assign w_wb_hit2 = (BYPASS != 0) && i_wb_valid && (i_wb_rd == i_rs2) && (i_rs2 != '0);

    assign o_rs1_busy = w_wb_hit1 ? (i_issue_valid && (i_issue_rd == i_rs1)) : r_busy[i_rs1];
    assign o_rs2_busy = w_wb_hit2 ? (i_issue_valid && (i_issue_rd == i_rs2)) : r_busy[i_rs2];
    assign o_busy_cnt = r_busy_cnt;

`ifdef REGFILE_DBG_EN
    assign o_busy_vec = r_busy;
`endif

endmodule : regfile_sb_scoreboard

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : 2R/1W integer register file with write-to-read bypass and a
//               busy scoreboard. Macro REGFILE_DBG_EN adds a debug read port
//               (dbg_sel/dbg_rdata) and the raw busy vector (dbg_busy_vec).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
    import rv_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREG   = NREG_DEFAULT,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_rdata,
    output logic [XLEN-1:0] rs2_rdata,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
`ifdef REGFILE_DBG_EN
    ,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [NREG-1:0] dbg_busy_vec
`endif
);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_en;
    logic            w_fwd1;
    logic            w_fwd2;

    assign w_wr_en = wb_valid && (wb_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                r_regs[r] <= '0;
        end else if (w_wr_en) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    assign w_fwd1 = (BYPASS != 0) && w_wr_en && (wb_rd == rs1);
    assign w_fwd2 = (BYPASS != 0) && w_wr_en && (wb_rd == rs2);

    assign rs1_rdata = (rs1 == '0) ? '0 : (w_fwd1 ? wb_data : r_regs[rs1]);
    assign rs2_rdata = (rs2 == '0) ? '0 : (w_fwd2 ? wb_data : r_regs[rs2]);

`ifdef REGFILE_DBG_EN
    assign dbg_rdata = (dbg_sel == '0) ? '0 : r_regs[dbg_sel];
`endif

    regfile_sb_scoreboard #(
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (flush),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .o_rs1_busy    (rs1_busy),
        .o_rs2_busy    (rs2_busy),
        .o_busy_cnt    (busy_cnt)
`ifdef REGFILE_DBG_EN
        ,
        .o_busy_vec    (dbg_busy_vec)
`endif
    );

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed self-checking bench; a bypassing and a non-bypassing
//               instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, issue_rd, wb_rd;
    logic            issue_valid, wb_valid, flush;
    logic [XLEN-1:0] wb_data;

    logic [XLEN-1:0] b_rs1_rdata, b_rs2_rdata, n_rs1_rdata, n_rs2_rdata;
    logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic [AW:0]     b_busy_cnt, n_busy_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef REGFILE_DBG_EN
    logic [AW-1:0]   dbg_sel;
    logic [XLEN-1:0] b_dbg_rdata, n_dbg_rdata;
    logic [NREG-1:0] b_dbg_busy_vec, n_dbg_busy_vec;
`endif

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .rs1_rdata(b_rs1_rdata), .rs2_rdata(b_rs2_rdata),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .busy_cnt(b_busy_cnt)
`ifdef REGFILE_DBG_EN
        , .dbg_sel(dbg_sel), .dbg_rdata(b_dbg_rdata), .dbg_busy_vec(b_dbg_busy_vec)
`endif
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .rs1_rdata(n_rs1_rdata), .rs2_rdata(n_rs2_rdata),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .busy_cnt(n_busy_cnt)
`ifdef REGFILE_DBG_EN
        , .dbg_sel(dbg_sel), .dbg_rdata(n_dbg_rdata), .dbg_busy_vec(n_dbg_busy_vec)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0;
        wb_valid    = 1'b0; wb_rd    = '0; wb_data = '0;
        flush       = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        idle();
        issue_valid = 1'b1; issue_rd = rd;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rs1 = '0; rs2 = '0;
`ifdef REGFILE_DBG_EN
        dbg_sel = '0;
`endif
        idle();
        tick(); tick();
        @(negedge clk); rst_n = 1'b1;
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        n_vec++;
        if ({b_rs1_rdata, b_rs2_rdata} !== 64'd0) begin
            n_err++; $display("FAIL reset_rdata got %h/%h want 0/0", b_rs1_rdata, b_rs2_rdata);
        end
        n_vec++;
        if ({b_rs1_busy, b_rs2_busy, b_busy_cnt, n_busy_cnt} !== '0) begin
            n_err++; $display("FAIL reset_busy got %b/%b cnt %0d/%0d want 0", b_rs1_busy, b_rs2_busy, b_busy_cnt, n_busy_cnt);
        end
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF; rs1 = 5'd0;
        #1;
        n_vec++;
        if (b_rs1_rdata !== 32'd0) begin
            n_err++; $display("FAIL x0_bypass got %h want 0", b_rs1_rdata);
        end
        tick(); idle();
        #1;
        n_vec++;
        if (b_rs1_rdata !== 32'd0 || b_busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL x0_write got %h cnt %0d want 0 cnt 0", b_rs1_rdata, b_busy_cnt);
        end
    endtask

    task automatic test_issue_wb();
        issue(5'd7); idle(); rs1 = 5'd7;
        #1;
        n_vec++;
        if (b_rs1_busy !== 1'b1 || b_busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL issue7 got busy %b cnt %0d want 1 cnt 1", b_rs1_busy, b_busy_cnt);
        end
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
        #1;
        n_vec++;
        if (b_rs1_rdata !== 32'h1234 || b_rs1_busy !== 1'b0) begin
            n_err++; $display("FAIL bypass7 got %h busy %b want 00001234 busy 0", b_rs1_rdata, b_rs1_busy);
        end
        n_vec++;
        if (n_rs1_rdata !== 32'd0 || n_rs1_busy !== 1'b1) begin
            n_err++; $display("FAIL nobypass7 got %h busy %b want 0 busy 1", n_rs1_rdata, n_rs1_busy);
        end
        tick(); idle();
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd0 || n_rs1_rdata !== 32'h1234 || n_rs1_busy !== 1'b0) begin
            n_err++; $display("FAIL wb7_done got cnt %0d data %h busy %b want 0 00001234 0", b_busy_cnt, n_rs1_rdata, n_rs1_busy);
        end
    endtask

    task automatic test_nobypass();
        idle(); rs2 = 5'd3;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hA5;
        #1;
        n_vec++;
        if (n_rs2_rdata !== 32'd0 || b_rs2_rdata !== 32'hA5) begin
            n_err++; $display("FAIL same_cycle_wb3 got nb %h byp %h want 0 / a5", n_rs2_rdata, b_rs2_rdata);
        end
        tick(); idle();
        #1;
        n_vec++;
        if (n_rs2_rdata !== 32'hA5 || n_busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL stored3 got %h cnt %0d want a5 cnt 0", n_rs2_rdata, n_busy_cnt);
        end
    endtask

    task automatic test_issue_wb_same();
        idle(); rs1 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
        #1;
        n_vec++;
        if (b_rs1_rdata !== 32'h55 || b_rs1_busy !== 1'b1) begin
            n_err++; $display("FAIL reissue9_read got %h busy %b want 55 busy 1", b_rs1_rdata, b_rs1_busy);
        end
        tick(); idle();
        #1;
        n_vec++;
        if (n_rs1_rdata !== 32'h55 || n_rs1_busy !== 1'b1 || b_busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL reissue9_state got %h busy %b cnt %0d want 55 1 1", n_rs1_rdata, n_rs1_busy, b_busy_cnt);
        end
        issue_valid = 1'b1; issue_rd = 5'd9;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h66;
        tick(); idle();
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd1 || n_rs1_busy !== 1'b1 || n_rs1_rdata !== 32'h66) begin
            n_err++; $display("FAIL busy9_again got cnt %0d busy %b data %h want 1 1 66", b_busy_cnt, n_rs1_busy, n_rs1_rdata);
        end
    endtask

    task automatic test_back_to_back();
        // reg9 busy (cnt 1): issue 10 while clearing 9 -> net 0; then issue 11 with wb to idle 12 -> +1
        idle();
        issue_valid = 1'b1; issue_rd = 5'd10;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        tick(); idle();
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL swap_9_10 got cnt %0d want 1", b_busy_cnt);
        end
        issue_valid = 1'b1; issue_rd = 5'd11;
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hC0FFEE;
        tick(); idle(); rs1 = 5'd12; rs2 = 5'd11;
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd2 || n_rs1_rdata !== 32'hC0FFEE || n_rs1_busy !== 1'b0 || n_rs2_busy !== 1'b1) begin
            n_err++; $display("FAIL wb_idle12 got cnt %0d data %h busy %b/%b want 2 c0ffee 0/1", b_busy_cnt, n_rs1_rdata, n_rs1_busy, n_rs2_busy);
        end
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick(); idle();
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd2) begin
            n_err++; $display("FAIL issue_x0 got cnt %0d want 2", b_busy_cnt);
        end
        flush = 1'b1;
        tick(); idle();
    endtask

    task automatic test_flush();
        logic [AW:0] exp_cnt;
        for (int i = 1; i <= 3; i++) begin
            issue(AW'(i)); idle();
            exp_cnt = (AW+1)'(i);
            #1;
            n_vec++;
            if (b_busy_cnt !== exp_cnt) begin
                n_err++; $display("FAIL issue_seq%0d got cnt %0d want %0d", i, b_busy_cnt, exp_cnt);
            end
        end
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd4;
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h77;
        tick(); idle(); rs1 = 5'd2; rs2 = 5'd4;
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd0 || n_busy_cnt !== 6'd0 || n_rs1_busy !== 1'b0 || n_rs2_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_busy got cnt %0d/%0d busy %b/%b want 0 0 0 0", b_busy_cnt, n_busy_cnt, n_rs1_busy, n_rs2_busy);
        end
        n_vec++;
        if (n_rs1_rdata !== 32'h77) begin
            n_err++; $display("FAIL flush_write2 got %h want 77", n_rs1_rdata);
        end
        rs1 = 5'd1; rs2 = 5'd3;
        #1;
        n_vec++;
        if (n_rs1_busy !== 1'b0 || n_rs2_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_busy13 got %b/%b want 0/0", n_rs1_busy, n_rs2_busy);
        end
`ifdef REGFILE_DBG_EN
        dbg_sel = 5'd2;
        #1;
        n_vec++;
        if (b_dbg_rdata !== 32'h77 || b_dbg_busy_vec !== '0) begin
            n_err++; $display("FAIL dbg_port got %h vec %h want 77 vec 0", b_dbg_rdata, b_dbg_busy_vec);
        end
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 3; i++) issue(AW'(i));
        idle();
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd3) begin
            n_err++; $display("FAIL pre_reset_cnt got %0d want 3", b_busy_cnt);
        end
        #1 rst_n = 1'b0;
        rs1 = 5'd2; rs2 = 5'd1;
        #1;
        n_vec++;
        if (b_busy_cnt !== 6'd0 || n_busy_cnt !== 6'd0 || n_rs2_busy !== 1'b0 || n_rs1_rdata !== 32'd0 || b_rs1_rdata !== 32'd0) begin
            n_err++; $display("FAIL async_reset got cnt %0d/%0d busy %b data %h want 0 0 0 0", b_busy_cnt, n_busy_cnt, n_rs2_busy, n_rs1_rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_issue_wb();
        test_nobypass();
        test_issue_wb_same();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_sb

`default_nettype wire
